// File: rtl/ps2_key_pkg.sv
// Shared types and byte constants for the PS/2 keyboard-line decoder.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_REL    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/ps2_key_if.sv
// Event word produced by the PS/2 decoder: toggle/make/ext/code plus a frame-error pulse.
interface ps2_key_if;

  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (output ps2_key, output frame_err);
  modport slave  (input  ps2_key, input  frame_err);

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stable-count glitch filter; output idles high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // The level only moves after FILTER_LEN consecutive cycles of disagreement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: frames bytes, resolves E0/F0/E1 prefixes, emits one ps2_key event per key.
// Optional PS2_WATCHDOG_EN aborts a stalled frame after TIMEOUT_CYC cycles.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 64000
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_key_if.master    key_bus
);

  if (FILTER_LEN < 1 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 131071) begin : g_param_check
    $error("ps2_key_decoder: FILTER_LEN or TIMEOUT_CYC out of range");
  end

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic       w_fall;
  logic       w_bit;
  logic       w_frame_ok;
  logic       w_wd_expire;

  assign w_raw = {ps2_data, ps2_clk};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .i_clk   (clk_sys),
      .i_rst_n (reset_n),
      .i_line  (w_raw[gi]),
      .o_level (w_filt[gi])
    );
  end

  ps2_state_t  r_state;
  logic        r_clk_prev;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_ext;
  logic        r_rel;
  logic [2:0]  r_skip;
  logic [10:0] r_key;
  logic        r_frame_err;

  assign w_fall     = r_clk_prev & ~w_filt[0];
  assign w_bit      = w_filt[1];
  assign w_frame_ok = (^{r_shift, r_parity}) & w_bit;

`ifdef PS2_WATCHDOG_EN
  logic [16:0] r_wd_cnt;
  logic        w_edge;

  assign w_edge      = r_clk_prev ^ w_filt[0];
  assign w_wd_expire = (r_wd_cnt == 17'(TIMEOUT_CYC));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (w_edge || r_state == IDLE) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 17'd1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_clk_prev  <= 1'b1;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_skip      <= '0;
      r_key       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_clk_prev  <= w_filt[0];
      if (w_wd_expire) begin
        r_state <= IDLE;
        r_ext   <= 1'b0;
        r_rel   <= 1'b0;
        r_skip  <= '0;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!w_bit) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
          DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_bit;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (!w_frame_ok) begin
              r_frame_err <= 1'b1;
              r_ext       <= 1'b0;
              r_rel       <= 1'b0;
            end else if (r_skip != 3'd0) begin
              // Pause: swallow the rest of the sequence, emit a single make at its end.
              r_skip <= r_skip - 3'd1;
              if (r_skip == 3'd1) r_key <= {~r_key[10], 1'b1, 1'b0, PAUSE_CODE};
            end else if (r_shift == PFX_EXT) begin
              r_ext <= 1'b1;
            end else if (r_shift == PFX_REL) begin
              r_rel <= 1'b1;
            end else if (r_shift == PFX_PAUSE) begin
              r_skip <= PAUSE_SKIP;
            end else begin
              r_key <= {~r_key[10], ~r_rel, r_ext, r_shift};
              r_ext <= 1'b0;
              r_rel <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign key_bus.ps2_key   = r_key;
  assign key_bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: byte-level protocol model, per-cycle event compare, literal pins.
// The watchdog scenario runs only when PS2_WATCHDOG_EN is defined.
module tb_ps2_key_decoder;

  localparam int H = 40;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk_drv = 1'b1;
  logic ps2_data_drv = 1'b1;

  ps2_key_if key_bus ();

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(2000)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk_drv),
    .ps2_data (ps2_data_drv),
    .key_bus  (key_bus)
  );

  always #8 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;

  // Protocol model state (byte level)
  bit          m_tog = 1'b0;
  bit          m_ext = 1'b0;
  bit          m_rel = 1'b0;
  int          m_skip = 0;
  logic [10:0] exp_q[$];
  int          err_exp = 0;
  int          err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic void push_event(input bit make, input bit ext, input logic [7:0] code);
    m_tog = ~m_tog;
    exp_q.push_back({m_tog, make, ext, code});
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
      err_exp++;
    end else if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) push_event(1'b1, 1'b0, 8'h77);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else begin
      push_event(~m_rel, m_ext, b);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_tog = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
    exp_q.delete();
  endfunction

  // Compare process: every change of ps2_key must be the next modelled event.
  logic [10:0] prev_key = 11'h000;
  logic        prev_err = 1'b0;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev_key = 11'h000;
      prev_err = 1'b0;
    end else begin
      if (key_bus.ps2_key !== prev_key) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h, required no event", key_bus.ps2_key);
        end else begin
          check("event", 32'(key_bus.ps2_key), 32'(exp_q.pop_front()));
        end
        prev_key = key_bus.ps2_key;
      end
      if (key_bus.frame_err === 1'b1) begin
        err_seen++;
        check("frame_err_width", 32'(prev_err), 32'd0);
      end
      prev_err = key_bus.frame_err;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_drv = fr[i];
      wait_cyc(H);
      ps2_clk_drv = 1'b0;
      wait_cyc(H);
      ps2_clk_drv = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip_par, input bit stop_bit);
    logic par;
    par = ~(^b) ^ flip_par;
    model_byte(b, !flip_par && stop_bit);
    send_bits({stop_bit, par, b, 1'b0}, 11);
    ps2_data_drv = 1'b1;
    wait_cyc(H);
  endtask

  task automatic end_check(input string name);
    int budget;
    budget = 4 * H;
    while (exp_q.size() != 0 && budget > 0) begin
      wait_cyc(1);
      budget--;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_errs"}, 32'(err_seen), 32'(err_exp));
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(5);
    check("reset_key", 32'(key_bus.ps2_key), 32'h000);
    check("reset_err", 32'(key_bus.frame_err), 32'd0);

    // Short glitches on both lines must be rejected by the filter.
    for (int g = 0; g < 4; g++) begin
      ps2_clk_drv = 1'b0;
      ps2_data_drv = 1'b0;
      wait_cyc(3);
      ps2_clk_drv = 1'b1;
      ps2_data_drv = 1'b1;
      wait_cyc(12);
    end
    check("glitch_key", 32'(key_bus.ps2_key), 32'h000);
    end_check("glitch");

    // A falling edge with data high in IDLE is not a start bit.
    send_bits(11'h001, 1);
    wait_cyc(H);

    send_byte(8'h1C, 1'b0, 1'b1);
    end_check("make_1c");
    check("make_1c_lit", 32'(key_bus.ps2_key), 32'h61C);

    send_byte(8'hE0, 1'b0, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b1);
    send_byte(8'h75, 1'b0, 1'b1);
    end_check("ext_break");
    check("ext_break_lit", 32'(key_bus.ps2_key), 32'h175);
    send_byte(8'h1C, 1'b0, 1'b1);
    end_check("after_break");
    check("after_break_lit", 32'(key_bus.ps2_key), 32'h61C);

    send_byte(8'h1C, 1'b1, 1'b1);
    check("bad_par_key", 32'(key_bus.ps2_key), 32'h61C);
    send_byte(8'h1C, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b1);
    send_byte(8'h1C, 1'b1, 1'b1);
    send_byte(8'h1C, 1'b0, 1'b1);
    end_check("errors");
    check("err_total", 32'(err_seen), 32'd3);
    check("err_recover_lit", 32'(key_bus.ps2_key), 32'h21C);

    send_byte(8'hE1, 1'b0, 1'b1);
    send_byte(8'h14, 1'b0, 1'b1);
    send_byte(8'h77, 1'b0, 1'b1);
    send_byte(8'hE1, 1'b0, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b1);
    send_byte(8'h14, 1'b0, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b1);
    send_byte(8'h77, 1'b0, 1'b1);
    end_check("pause");
    check("pause_lit", 32'(key_bus.ps2_key), 32'h677);

    // Reset in the middle of a frame: outputs clear at once, next frame is clean.
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    wait_cyc(H / 2);
    #3 reset_n = 1'b0;
    model_reset();
    #1 check("async_reset_key", 32'(key_bus.ps2_key), 32'h000);
    ps2_clk_drv = 1'b1;
    ps2_data_drv = 1'b1;
    wait_cyc(20);
    reset_n = 1'b1;
    wait_cyc(20);
    send_byte(8'h1C, 1'b0, 1'b1);
    end_check("post_reset");
    check("post_reset_lit", 32'(key_bus.ps2_key), 32'h61C);

`ifdef PS2_WATCHDOG_EN
    send_byte(8'hE0, 1'b0, 1'b1);
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
    ps2_data_drv = 1'b1;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
    wait_cyc(2100);
    send_byte(8'h1C, 1'b0, 1'b1);
    end_check("watchdog");
    check("watchdog_lit", 32'(key_bus.ps2_key), 32'h21C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
